// File: rtl/prbs_if.sv
// Output stream of the pattern generator: a valid/ready word channel.
// The generator drives the master side and the consumer drives the slave side.
interface prbs_if #(
  parameter int WIDTH = 8
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output out_valid,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/prbs_gen.sv
// Pattern generator: Galois PRBS, increment, walking-one or hold, advancing one word per
// accepted handshake, with seed load, wrap detection and all-zero PRBS lockup escape.
module prbs_gen #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] POLY      = 8'h71,
  parameter logic [WIDTH-1:0] SEED_INIT = 8'h01
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  input  logic [1:0]       mode,
  prbs_if.master           bus,
  output logic             wrap,
  output logic             lockup
);

  localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]       MODE_PRBS = 2'b00;
  localparam logic [1:0]       MODE_INC  = 2'b01;
  localparam logic [1:0]       MODE_WALK = 2'b10;
  localparam logic [1:0]       MODE_HOLD = 2'b11;

  logic [WIDTH-1:0] state_reg, state_next;
  logic [WIDTH-1:0] start_reg, start_next;
  logic             valid_reg, valid_next;
  logic             wrap_reg, wrap_next;
  logic             lockup_reg, lockup_next;
  logic [WIDTH-1:0] prbs_step;
  logic [WIDTH-1:0] adv_value;
  logic             handshake;

  // Galois step: shift left, folding the outgoing MSB back through the tap mask.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_prbs_bit
      if (gi == 0) begin : g_lsb
        assign prbs_step[gi] = state_reg[WIDTH-1] & POLY[gi];
      end else begin : g_upper
        assign prbs_step[gi] = state_reg[gi-1] ^ (state_reg[WIDTH-1] & POLY[gi]);
      end
    end
  endgenerate

  assign handshake = valid_reg & bus.out_ready & ~load;

  always_comb begin
    adv_value = state_reg;
    case (mode)
      MODE_PRBS: adv_value = (state_reg == '0) ? ONE : prbs_step;
      MODE_INC:  adv_value = state_reg + ONE;
      MODE_WALK: adv_value = (state_reg == '0) ? ONE
                                               : {state_reg[WIDTH-2:0], state_reg[WIDTH-1]};
      MODE_HOLD: adv_value = state_reg;
      default:   adv_value = state_reg;
    endcase
  end

  always_comb begin
    state_next  = state_reg;
    start_next  = start_reg;
    wrap_next   = 1'b0;
    lockup_next = 1'b0;
    valid_next  = en & ~load;
    if (load) begin
      // A zero seed would freeze the PRBS, so it is replaced by 1 and flagged.
      if (mode == MODE_PRBS && seed == '0) begin
        state_next  = ONE;
        start_next  = ONE;
        lockup_next = 1'b1;
      end else begin
        state_next = seed;
        start_next = seed;
      end
    end else if (handshake && mode != MODE_HOLD) begin
      state_next  = adv_value;
      wrap_next   = (adv_value == start_reg);
      lockup_next = (mode == MODE_PRBS) && (state_reg == '0);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_reg  <= SEED_INIT;
      start_reg  <= SEED_INIT;
      valid_reg  <= 1'b0;
      wrap_reg   <= 1'b0;
      lockup_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      start_reg  <= start_next;
      valid_reg  <= valid_next;
      wrap_reg   <= wrap_next;
      lockup_reg <= lockup_next;
    end
  end

  assign bus.out_valid = valid_reg;
  assign bus.out_data  = state_reg;
  assign wrap          = wrap_reg;
  assign lockup        = lockup_reg;

endmodule

// File: doc/prbs_gen.md
PRBS_GEN -- requirements
Module: prbs_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning register width in bits (legal 3..32).
REQ-002 SHALL have parameter POLY, default 8'h71, meaning Galois coefficients of x^0..x^(WIDTH-1) with x^WIDTH implicit; the default encodes x^8+x^6+x^5+x^4+1.
REQ-003 SHALL have parameter SEED_INIT, default 8'h01, meaning the nonzero state loaded at reset.
REQ-004 SHALL have port sys_clk  input  1  clock; all logic is rising-edge.
REQ-005 SHALL have port sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  generator enable.
REQ-007 SHALL have port load  input  1  synchronous seed-load strobe.
REQ-008 SHALL have port seed  input  WIDTH  value loaded on load.
REQ-009 SHALL have port mode  input  2  pattern select: 00 PRBS, 01 increment, 10 walking-one, 11 hold.
REQ-010 SHALL have port out_ready  input  1  consumer ready.
REQ-011 SHALL have port out_valid  output  1  out_data is valid.
REQ-012 SHALL have port out_data  output  WIDTH  current pattern word, driven directly from the state register.
REQ-013 SHALL have port wrap  output  1  one-cycle pulse when the sequence returns to its start value.
REQ-014 SHALL have port lockup  output  1  one-cycle pulse when an all-zero PRBS state is escaped.

Function
REQ-015 SHALL drive out_valid registered: the value of en sampled at the previous rising edge, and 0 while load is high.
REQ-016 SHALL advance the state only on a handshake, defined as out_valid & out_ready & ~load at a rising edge; with no handshake, state and out_data hold.
REQ-017 SHALL apply the PRBS (mode 00) advance as next = (state << 1) XOR (POLY when state[WIDTH-1]=1, else 0), truncated to WIDTH.
REQ-018 SHALL, in PRBS mode, advance an all-zero state to 1 instead of applying REQ-017, and pulse lockup for one cycle.
REQ-019 SHALL apply the increment (mode 01) advance as next = state + 1 modulo 2^WIDTH, wrapping all-ones to 0.
REQ-020 SHALL apply the walking-one (mode 10) advance as a rotate-left by 1; if state is 0, next = 1.
REQ-021 SHALL leave the state unchanged on a hold (mode 11) advance; the handshake still completes and out_valid follows en.
REQ-022 SHALL apply a mode change mid-stream at the next advance, using the current state as the starting point; no implicit reload.
REQ-023 SHALL, on load=1 at a rising edge, set state = seed and start = seed; load has priority over any handshake in the same cycle.
REQ-024 SHALL, if load=1 in PRBS mode with seed = 0, load 1 instead of 0 and pulse lockup.
REQ-025 SHALL pulse wrap for one cycle after any advance whose next state equals start, except in mode 11.
REQ-026 SHALL keep wrap and lockup at 0 in every cycle without a qualifying event.
REQ-027 SHALL, when en is deasserted, drop out_valid one cycle later and retain the state; re-enable resumes the sequence without a gap or repeat.
REQ-028 SHALL give the default parameters a period of 255 handshakes in PRBS mode (maximal length).

Reset
REQ-029 SHALL, while sys_rst_n=0, immediately force state = SEED_INIT, start = SEED_INIT, out_valid = 0, wrap = 0 and lockup = 0, independent of sys_clk.
REQ-030 SHALL resume operation after reset deassertion with out_data = SEED_INIT; the first handshake is possible no earlier than the second rising edge after release with en=1.
REQ-031 SHALL, when reset is asserted mid-stream, discard any in-flight handshake; no partial state update is permitted.

Verification
REQ-032 SHALL cover: reset, en=1, mode=00, out_ready=1 -> out_data sequence 01,02,04,08,10,20,40,80,71,E2,B5.
REQ-033 SHALL cover: default parameters, PRBS free-run from 01 -> wrap pulses exactly once after 255 handshakes, with no repeat of any value before that and 00 never appearing.
REQ-034 SHALL cover: load=1 with seed=00 in mode 00 -> out_data=01 and a lockup pulse; load seed=3C in mode 01 with 4 handshakes -> 3D,3E,3F,40.
REQ-035 SHALL cover: mode=10 from seed 80 -> 01,02,04; toggle out_ready 1/0 every cycle -> each word is held until accepted, with no skips.
REQ-036 SHALL cover: load and a handshake in the same cycle -> out_data=seed and out_valid=0 that cycle; mode switch 00->01 at state E2 -> next value E3.
REQ-037 SHALL cover: async reset asserted between edges mid-stream -> outputs go to reset values at once; after release, out_data=01 and the sequence restarts.
